demux_32bit_3_reg: RTL and testbench
====================================

// Module: demux_32bit_3_reg
// PURPOSE
//   Registered 1-to-3 demultiplexer: the distribution counterpart of the 3:1 32-bit source mux.
//   Routes one input word to one of three destination ports selected by in_sel.
//   Valid/ready handshake on the input and on each output.
//   Sits between a producer (e.g. ALU/write-back path) and three consumers.
//   Each output has its own one-entry buffer, so a stalled consumer blocks only its own traffic.
// PARAMETERS
//   WIDTH   32  data width of input and each output
//   CNT_W   8   width of the saturating dropped-word counter
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_data    in   WIDTH  word to route
//   in_sel     in   2      destination: 00->out0, 01->out1, 10->out2, 11->illegal
//   in_valid   in   1      in_data/in_sel valid this cycle
//   in_ready   out  1      block accepts the word this cycle (combinational)
//   out0_data  out  WIDTH  buffered word for destination 0 (out1_*, out2_* identical)
//   out0_valid out  1      out0_data holds an undelivered word
//   out0_ready in   1      consumer 0 takes the word this cycle
//   err_sel    out  1      one-cycle pulse: an illegal-select word was dropped
//   drop_cnt   out  CNT_W  count of dropped illegal-select words, saturating
// BEHAVIOUR
//   Reset (async assert, sync release): all outN_valid=0, all outN_data=0, err_sel=0, drop_cnt=0.
//   Per-output buffer FSM, states EMPTY / FULL (outN_valid = FULL):
//     EMPTY -> FULL   on accept with in_sel=N; outN_data <= in_data.
//     FULL  -> EMPTY  on outN_ready and no new accept for N.
//     FULL  -> FULL   on outN_ready and accept for N in the same cycle; data replaced, no bubble.
//     FULL  holds data unchanged while outN_ready=0.
//   in_ready:
//     - in_sel=N (0..2): 1 if buffer N is EMPTY, or FULL and outN_ready=1.
//     - in_sel=11: always 1.
//   in_ready does not depend on the state of the other two buffers.
//   Accept = in_valid & in_ready.
//   Latency: a word accepted at edge k appears on outN_* after edge k (visible cycle k+1).
//   Illegal select: an accepted word with in_sel=11 is discarded and no output changes.
//     On that edge err_sel=1 for one cycle and drop_cnt increments.
//     drop_cnt saturates at 2^CNT_W-1 (no wrap-around).
//   err_sel is registered and is 0 in every cycle without a drop.
//   in_valid=0: in_sel and in_data are ignored, and no state changes except outputs draining.
//   Simultaneous drains on several outputs are independent, and each drains in the same cycle.
//   outN_data is stable while outN_valid=1 and outN_ready=0.
//   rst_n low mid-transfer: buffered words are lost, valids clear immediately (asynchronously),
//   and drop_cnt is cleared.
//   in_ready is 1 while rst_n=0 only if it is computed with all buffers EMPTY.
//   Producers must not present in_valid during reset.
// TESTING
//   1. Reset: rst_n=0 with all inputs toggling.
//      -> all outN_valid=0, outN_data=0, drop_cnt=0, err_sel=0.
//   2. Routing: send 0xDEADBEEF sel=00, 0x12345678 sel=01, 0xCAFEF00D sel=10 with outs ready=1.
//      -> each word appears on its own port one cycle after accept; the other ports stay invalid.
//   3. Backpressure: out1_ready=0, send 0xA sel=01 then 0xB sel=01.
//      -> second word sees in_ready=0 and out1_data holds 0xA.
//      -> set out1_ready=1: 0xB is accepted in that same cycle, with no bubble.
//   4. Isolation: out0 full and stalled, send 0x55 sel=10.
//      -> in_ready=1 and out2_data=0x55 next cycle; out0 is unchanged.
//   5. Illegal select: send 0xFFFFFFFF sel=11.
//      -> in_ready=1, err_sel pulses 1 cycle, drop_cnt 0->1, no outN_valid rises.
//      -> 300 drops with CNT_W=8 leave drop_cnt=255.
//   6. Reset mid-operation: all three buffers full, assert rst_n=0 between clock edges.
//      -> valids drop immediately; after release the block accepts 0x1 sel=00 normally.

Source files
------------

// File: rtl/demux_32bit_3_reg_if.sv
// Purpose: bundles the routing handshake of demux_32bit_3_reg.
//   Input side:  in_data/in_sel/in_valid from the producer, in_ready back to it.
//   Output side: outN_data/outN_valid to consumer N, outN_ready from it (N = 0..2).
//   Status:      err_sel pulse and drop_cnt for illegal-select words.
// master = producer/consumer environment, slave = the demux itself.
interface demux_32bit_3_reg_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out2_data;
  logic             out2_valid;
  logic             out2_ready;

  logic             err_sel;
  logic [CNT_W-1:0] drop_cnt;

  modport slave (
    input  in_data, in_sel, in_valid,
    input  out0_ready, out1_ready, out2_ready,
    output in_ready,
    output out0_data, out0_valid, out1_data, out1_valid, out2_data, out2_valid,
    output err_sel, drop_cnt
  );

  modport master (
    output in_data, in_sel, in_valid,
    output out0_ready, out1_ready, out2_ready,
    input  in_ready,
    input  out0_data, out0_valid, out1_data, out1_valid, out2_data, out2_valid,
    input  err_sel, drop_cnt
  );
endinterface

// File: rtl/demux_32bit_3_reg.sv
// Purpose: registered 1-to-3 demultiplexer with a one-entry buffer per output.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : demux_32bit_3_reg_if.slave carrying the input handshake,
//                three output handshakes, err_sel pulse and saturating drop_cnt.
// in_ready is combinational; every other output comes straight from a flop.
module demux_32bit_3_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_32bit_3_reg_if.slave    bus
);

  localparam int unsigned N_OUT = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  buf_state_e       state_q [N_OUT];
  buf_state_e       state_d [N_OUT];
  logic [WIDTH-1:0] data_q  [N_OUT];
  logic [WIDTH-1:0] data_d  [N_OUT];
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [N_OUT-1:0] out_ready;
  logic [N_OUT-1:0] accept;
  logic             drop;
  logic             in_ready_c;

  assign out_ready = {bus.out2_ready, bus.out1_ready, bus.out0_ready};

  // Readiness looks only at the selected buffer; a full buffer still accepts
  // when its consumer drains in the same cycle.
  always_comb begin : ready_decode
    in_ready_c = 1'b1;
    case (bus.in_sel)
      2'd0:    in_ready_c = (state_q[0] == EMPTY) || out_ready[0];
      2'd1:    in_ready_c = (state_q[1] == EMPTY) || out_ready[1];
      2'd2:    in_ready_c = (state_q[2] == EMPTY) || out_ready[2];
      default: in_ready_c = 1'b1;
    endcase
  end

  assign bus.in_ready = in_ready_c;

  // Per-destination accept strobes; select 11 is swallowed as a drop.
  always_comb begin : accept_decode
    accept = '0;
    drop   = 1'b0;
    if (bus.in_valid && in_ready_c) begin
      for (int unsigned n = 0; n < N_OUT; n++) begin
        accept[n] = (bus.in_sel == 2'(n));
      end
      drop = (bus.in_sel == 2'd3);
    end
  end

  // Buffer FSMs plus drop bookkeeping.
  always_comb begin : next_state
    for (int unsigned n = 0; n < N_OUT; n++) begin
      state_d[n] = state_q[n];
      data_d[n]  = data_q[n];
      if (accept[n]) begin
        state_d[n] = FULL;
        data_d[n]  = bus.in_data;
      end else if ((state_q[n] == FULL) && out_ready[n]) begin
        state_d[n] = EMPTY;
      end
    end
    err_d = drop;
    cnt_d = cnt_q;
    if (drop && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      for (int unsigned n = 0; n < N_OUT; n++) begin
        state_q[n] <= EMPTY;
        data_q[n]  <= '0;
      end
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int unsigned n = 0; n < N_OUT; n++) begin
        state_q[n] <= state_d[n];
        data_q[n]  <= data_d[n];
      end
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.out0_data  = data_q[0];
  assign bus.out1_data  = data_q[1];
  assign bus.out2_data  = data_q[2];
  assign bus.out0_valid = (state_q[0] == FULL);
  assign bus.out1_valid = (state_q[1] == FULL);
  assign bus.out2_valid = (state_q[2] == FULL);
  assign bus.err_sel    = err_q;
  assign bus.drop_cnt   = cnt_q;

endmodule

// File: tb/tb_demux_32bit_3_reg.sv
// Bench for demux_32bit_3_reg: vector table for handshake/valid behaviour,
// scoreboard queues for delivered data, reference model for err_sel/drop_cnt.
module tb_demux_32bit_3_reg;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  demux_32bit_3_reg_if #(.WIDTH(32), .CNT_W(8)) bus ();

  demux_32bit_3_reg #(.WIDTH(32), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        valid;
    logic [2:0]  rdy;        // {out2_ready, out1_ready, out0_ready}
    logic        exp_ready;  // in_ready with these inputs applied
    logic [2:0]  exp_v;      // {out2_valid, out1_valid, out0_valid} after the edge
    logic        exp_err;    // err_sel after the edge
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  int unsigned model_cnt = 0;
  logic        model_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] s, input logic v, input logic [2:0] r);
    bus.in_data    = d;
    bus.in_sel     = s;
    bus.in_valid   = v;
    bus.out0_ready = r[0];
    bus.out1_ready = r[1];
    bus.out2_ready = r[2];
  endtask

  function automatic logic [2:0] valids();
    return {bus.out2_valid, bus.out1_valid, bus.out0_valid};
  endfunction

  // Scoreboard/model update, sampled 1ns before each rising edge.
  always begin
    logic [31:0] exp_w;
    @(negedge clk);
    #4;
    if (!rst_n) begin
      q0.delete(); q1.delete(); q2.delete();
      model_cnt = 0;
      model_err = 1'b0;
    end else begin
      if (bus.out0_valid && bus.out0_ready) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_out0: delivered 0x%0h, required nothing", bus.out0_data);
        end else begin
          exp_w = q0.pop_front();
          check("sb_out0_data", bus.out0_data, exp_w);
        end
      end
      if (bus.out1_valid && bus.out1_ready) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_out1: delivered 0x%0h, required nothing", bus.out1_data);
        end else begin
          exp_w = q1.pop_front();
          check("sb_out1_data", bus.out1_data, exp_w);
        end
      end
      if (bus.out2_valid && bus.out2_ready) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_out2: delivered 0x%0h, required nothing", bus.out2_data);
        end else begin
          exp_w = q2.pop_front();
          check("sb_out2_data", bus.out2_data, exp_w);
        end
      end
      model_err = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        case (bus.in_sel)
          2'd0: q0.push_back(bus.in_data);
          2'd1: q1.push_back(bus.in_data);
          2'd2: q2.push_back(bus.in_data);
          default: begin
            model_err = 1'b1;
            if (model_cnt != 255) model_cnt++;
          end
        endcase
      end
    end
  end

  // Status outputs checked against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("err_sel", 32'(bus.err_sel), 32'(model_err));
      check("drop_cnt", 32'(bus.drop_cnt), model_cnt);
    end
  end

  initial begin
    // routing
    vecs[0]  = '{32'hDEADBEEF, 2'd0, 1'b1, 3'b111, 1'b1, 3'b001, 1'b0};
    vecs[1]  = '{32'h12345678, 2'd1, 1'b1, 3'b111, 1'b1, 3'b010, 1'b0};
    vecs[2]  = '{32'hCAFEF00D, 2'd2, 1'b1, 3'b111, 1'b1, 3'b100, 1'b0};
    vecs[3]  = '{32'h0BAD0BAD, 2'd0, 1'b0, 3'b111, 1'b1, 3'b000, 1'b0};
    // backpressure on out1, then same-cycle replace
    vecs[4]  = '{32'h0000000A, 2'd1, 1'b1, 3'b101, 1'b1, 3'b010, 1'b0};
    vecs[5]  = '{32'h0000000B, 2'd1, 1'b1, 3'b101, 1'b0, 3'b010, 1'b0};
    vecs[6]  = '{32'h0000000B, 2'd1, 1'b1, 3'b111, 1'b1, 3'b010, 1'b0};
    vecs[7]  = '{32'h0BAD0BAD, 2'd1, 1'b0, 3'b111, 1'b1, 3'b000, 1'b0};
    // isolation: out0 stalled while out2 traffic flows
    vecs[8]  = '{32'h00000077, 2'd0, 1'b1, 3'b110, 1'b1, 3'b001, 1'b0};
    vecs[9]  = '{32'h00000055, 2'd2, 1'b1, 3'b110, 1'b1, 3'b101, 1'b0};
    vecs[10] = '{32'h0BAD0BAD, 2'd0, 1'b0, 3'b110, 1'b0, 3'b001, 1'b0};
    vecs[11] = '{32'h0BAD0BAD, 2'd1, 1'b0, 3'b110, 1'b1, 3'b001, 1'b0};
    vecs[12] = '{32'h0BAD0BAD, 2'd0, 1'b0, 3'b111, 1'b1, 3'b000, 1'b0};
    // illegal select
    vecs[13] = '{32'hFFFFFFFF, 2'd3, 1'b1, 3'b111, 1'b1, 3'b000, 1'b1};
    vecs[14] = '{32'h0BAD0BAD, 2'd3, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0};
    // fill all three, drop with everything stalled, then drain together
    vecs[15] = '{32'h00000001, 2'd0, 1'b1, 3'b000, 1'b1, 3'b001, 1'b0};
    vecs[16] = '{32'h00000002, 2'd1, 1'b1, 3'b000, 1'b1, 3'b011, 1'b0};
    vecs[17] = '{32'h00000003, 2'd2, 1'b1, 3'b000, 1'b1, 3'b111, 1'b0};
    vecs[18] = '{32'h00000004, 2'd3, 1'b1, 3'b000, 1'b1, 3'b111, 1'b1};
    vecs[19] = '{32'h0BAD0BAD, 2'd0, 1'b0, 3'b111, 1'b1, 3'b000, 1'b0};

    // Reset with toggling inputs
    rst_n = 1'b0;
    drive('0, 2'd0, 1'b0, 3'b000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      drive($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      #1;
      check("rst_valid", 32'(valids()), 32'd0);
      check("rst_data", bus.out0_data | bus.out1_data | bus.out2_data, 32'd0);
      check("rst_err", 32'(bus.err_sel), 32'd0);
      check("rst_cnt", 32'(bus.drop_cnt), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    end
    @(negedge clk);
    #1;
    drive('0, 2'd0, 1'b0, 3'b111);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("v%0d_valid", i - 1), 32'(valids()), 32'(vecs[i-1].exp_v));
        check($sformatf("v%0d_err", i - 1), 32'(bus.err_sel), 32'(vecs[i-1].exp_err));
      end
      #1;
      drive(vecs[i].data, vecs[i].sel, vecs[i].valid, vecs[i].rdy);
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ready));
    end
    @(negedge clk);
    check("v19_valid", 32'(valids()), 32'(vecs[NV-1].exp_v));

    // Drop counter saturation
    for (int i = 0; i < 300; i++) begin
      #1;
      drive(32'hFFFFFFFF, 2'd3, 1'b1, 3'b111);
      @(negedge clk);
    end
    #1;
    drive('0, 2'd0, 1'b0, 3'b111);
    @(negedge clk);
    check("sat_drop_cnt", 32'(bus.drop_cnt), 32'd255);
    check("sat_err_clear", 32'(bus.err_sel), 32'd0);

    // Reset between edges with all buffers full
    #1; drive(32'h00000011, 2'd0, 1'b1, 3'b000);
    @(negedge clk);
    #1; drive(32'h00000022, 2'd1, 1'b1, 3'b000);
    @(negedge clk);
    #1; drive(32'h00000033, 2'd2, 1'b1, 3'b000);
    @(negedge clk);
    #1; drive('0, 2'd0, 1'b0, 3'b000);
    check("pre_rst_valid", 32'(valids()), 32'h7);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(valids()), 32'd0);
    check("async_rst_cnt", 32'(bus.drop_cnt), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    drive(32'h00000001, 2'd0, 1'b1, 3'b111);
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("post_rst_valid", 32'(valids()), 32'h1);
    check("post_rst_data", bus.out0_data, 32'h1);
    #1;
    drive('0, 2'd0, 1'b0, 3'b111);
    @(negedge clk);
    check("final_valid", 32'(valids()), 32'd0);
    @(negedge clk);
    check("sb_left", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
